// File: rtl/barcode.sv
// rtl/barcode.sv - serial barcode station-ID receiver with self-timed bit sampling
module barcode #(
    parameter int CNT_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FALL,
        BIT_CNT,
        CHECK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic             bc_meta;
    logic             sync;
    logic             prev_sync;
    logic             fall;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift;

    // Flops reset high so a line idling high never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_meta   <= 1'b1;
            sync      <= 1'b1;
            prev_sync <= 1'b1;
        end else begin
            bc_meta   <= BC;
            sync      <= bc_meta;
            prev_sync <= sync;
        end
    end

    assign fall = prev_sync & ~sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_cnt <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            ID         <= 8'h00;
            ID_vld     <= 1'b0;
        end else begin
            if (clr_ID_vld)
                ID_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        period_cnt <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    if (!sync) begin
                        if (period_cnt != CNT_MAX)
                            period_cnt <= period_cnt + CNT_W'(1);
                    end else begin
                        // period_cnt now holds the half-bit reference for this frame
                        bit_idx <= '0;
                        state   <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        state   <= BIT_CNT;
                    end
                end
                BIT_CNT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == period_cnt) begin
                        shift   <= {shift[6:0], sync};
                        bit_idx <= bit_idx + 4'd1;
                        state   <= (bit_idx == 4'd7) ? CHECK : WAIT_FALL;
                    end
                end
                CHECK: begin
                    // Acceptance overrides a same-cycle clear.
                    if (shift[7:6] == 2'b00) begin
                        ID     <= shift;
                        ID_vld <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barcode.sv
// tb/tb_barcode.sv - self-checking bench for barcode: vector table, corner sequences, random frames
module tb_barcode;

    logic       clk;
    logic       rst_n;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_id;
    logic       m_vld;

    barcode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         h;
        bit         clr_before;
        logic [7:0] exp_id;
        bit         exp_vld;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr_ID_vld = 1'b1;
        idle(1);
        clr_ID_vld = 1'b0;
    endtask

    // Start pulse: low h, high h. Bit: '1' low h/2, '0' low 3h/2, period 2h.
    // Optionally raises clr_ID_vld exactly on the clock edge where the frame is accepted.
    task automatic send_frame(input logic [7:0] v, input int h, input int nbits, input bit clr_acc);
        BC = 1'b0;
        for (int c = 1; c <= 2 * h; c++) begin
            idle(1);
            if (c == h) BC = 1'b1;
        end
        for (int b = 0; b < nbits; b++) begin
            logic [7:0] vv;
            int         low;
            vv  = v;
            low = vv[7-b] ? h / 2 : (3 * h) / 2;
            BC  = 1'b0;
            for (int c = 1; c <= 2 * h; c++) begin
                idle(1);
                if (c == low) BC = 1'b1;
                if (clr_acc && b == 7 && c == h + 3) clr_ID_vld = 1'b1;
                if (c == h + 4) clr_ID_vld = 1'b0;
            end
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] eid, input logic evld);
        idle(4);
        @(negedge clk);
        check({name, " ID"}, ID, eid);
        check({name, " ID_vld"}, {7'b0, ID_vld}, {7'b0, evld});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        BC         = 1'b1;
        clr_ID_vld = 1'b0;

        vecs[0] = '{8'h25, 100, 1'b0, 8'h25, 1'b1};
        vecs[1] = '{8'hC3, 100, 1'b0, 8'h25, 1'b1};
        vecs[2] = '{8'hC3, 100, 1'b1, 8'h25, 1'b0};
        vecs[3] = '{8'h01,  20, 1'b0, 8'h01, 1'b1};
        vecs[4] = '{8'h3F,  50, 1'b0, 8'h3F, 1'b1};
        vecs[5] = '{8'hFF,  30, 1'b1, 8'h3F, 1'b0};
        vecs[6] = '{8'h00,  16, 1'b0, 8'h00, 1'b1};

        idle(3);
        @(negedge clk);
        check("reset ID", ID, 8'h00);
        check("reset ID_vld", {7'b0, ID_vld}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr_before) pulse_clr();
            idle(3);
            send_frame(vecs[i].val, vecs[i].h, 8, 1'b0);
            check_out($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_vld);
        end

        // Acknowledge clears ID_vld the following cycle and leaves ID alone.
        send_frame(8'h25, 100, 8, 1'b0);
        check_out("reaccept 25", 8'h25, 1'b1);
        clr_ID_vld = 1'b1;
        idle(1);
        clr_ID_vld = 1'b0;
        @(negedge clk);
        check("clr ID_vld", {7'b0, ID_vld}, 8'h00);
        check("clr ID", ID, 8'h25);
        idle(3);

        // Overwrite while valid, with the clear landing in the acceptance cycle.
        send_frame(8'h12, 30, 8, 1'b0);
        check_out("pre 12", 8'h12, 1'b1);
        send_frame(8'h3F, 40, 8, 1'b1);
        check_out("set wins 3F", 8'h3F, 1'b1);

        // Reset mid-frame during bit 4, then a clean frame.
        send_frame(8'h12, 100, 3, 1'b0);
        BC = 1'b0;
        idle(30);
        rst_n = 1'b0;
        #1;
        check("midreset ID", ID, 8'h00);
        check("midreset ID_vld", {7'b0, ID_vld}, 8'h00);
        BC = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(5);
        check_out("post reset idle", 8'h00, 1'b0);
        send_frame(8'h12, 100, 8, 1'b0);
        check_out("after reset 12", 8'h12, 1'b1);

        m_id  = 8'h12;
        m_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            int         h;
            bit         clr;
            v   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) v[7:6] = 2'b00;
            h   = $urandom_range(8, 60);
            clr = ($urandom_range(0, 2) == 0);
            if (clr) begin
                pulse_clr();
                m_vld = 1'b0;
            end
            idle(3);
            send_frame(v, h, 8, 1'b0);
            if (v < 8'h40) begin
                m_id  = v;
                m_vld = 1'b1;
            end
            check_out($sformatf("rand%0d v=%h h=%0d", i, v, h), m_id, m_vld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barcode.md
BARCODE -- requirements
Module: barcode

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: BC  input  1  serial barcode line from the reader; asynchronous to clk; idles high.
REQ-004 SHALL have port: clr_ID_vld  input  1  consumer acknowledge; clears ID_vld.
REQ-005 SHALL have port: ID  output  8  last accepted station ID, MSB first on the line.
REQ-006 SHALL have port: ID_vld  output  1  new ID available; held until cleared.
REQ-007 SHALL have parameter: CNT_W, default 22, width of the period and bit counters.

Function
REQ-008 SHALL pass BC through two reset-to-1 synchronizer flops, plus a third flop for edge detection; fall = prev_sync & ~sync.
REQ-009 SHALL have states IDLE, START, WAIT_FALL, BIT_CNT and CHECK.
REQ-010 IDLE: on fall, clear period_cnt to 0 and enter START.
REQ-011 START: increment period_cnt each clk while sync==0.
REQ-012 START, sync rises: freeze period_cnt as the half-bit reference T, clear bit_idx to 0, and enter WAIT_FALL.
REQ-013 START: period_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 WAIT_FALL: on fall, clear bit_cnt to 0 and enter BIT_CNT.
REQ-015 BIT_CNT: increment bit_cnt each clk.
REQ-016 BIT_CNT, bit_cnt==T: shift sync into the shift-register LSB (shift left, MSB first) and increment bit_idx.
REQ-017 After that sample: if bit_idx reaches 8, enter CHECK; else enter WAIT_FALL.
REQ-018 Bit value: short low (line already high at sample) = 1; long low (still low) = 0.
REQ-019 CHECK, shift[7:6]==2'b00: load ID from the shift register and set ID_vld the next cycle; return to IDLE.
REQ-020 CHECK, shift[7:6]!=2'b00: discard the frame, leave ID and ID_vld unchanged; return to IDLE.
REQ-021 ID SHALL change only on acceptance in CHECK; it holds its value across later frames and rejects.
REQ-022 ID_vld SHALL stay 1 until clr_ID_vld is high on a clk edge, then read 0 the following cycle.
REQ-023 Accepting a new ID while ID_vld==1 SHALL overwrite ID and keep ID_vld at 1.
REQ-024 clr_ID_vld and acceptance in the same cycle: set wins, ID_vld=1.
REQ-025 Falls outside IDLE and WAIT_FALL SHALL be ignored.
REQ-026 Latency from the line edge to internal action SHALL be 2 clk (synchronizer); the bench measures pulse widths after this delay.
REQ-027 clr_ID_vld SHALL have no effect on frame reception.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, ID=8'h00, ID_vld=0, shift register, counters and bit_idx to 0, and synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial ID or ID_vld update.
REQ-030 After release, reception SHALL resume at the next fall seen in IDLE.

Verification
REQ-031 Start low 100 clk, then bits 0x25 MSB first (bit=1: 50 clk low; bit=0: 150 clk low; 200 clk period) -> ID_vld=1 after the 8th sample, ID=8'h25.
REQ-032 Same timing with 0xC3 -> ID_vld stays 0, ID keeps its prior value (8'h25 or 8'h00).
REQ-033 After 0x25 accepted, pulse clr_ID_vld for 1 clk -> ID_vld=0 next cycle, ID still 8'h25.
REQ-034 Send 0x3F while ID_vld=1, asserting clr_ID_vld in the CHECK-acceptance cycle -> ID_vld=1, ID=8'h3F.
REQ-035 Assert rst_n=0 during bit 4 of a 0x12 frame -> ID=0, ID_vld=0 at once; then a full 0x12 frame -> ID=8'h12, ID_vld=1.
REQ-036 Start low 20 clk followed by 0x01 -> ID=8'h01, ID_vld=1, covering the short-period boundary.
